pipe_control_unit: RTL and testbench

Pipelined successor to the single-cycle control unit. It decodes `op`/`funct3`/`funct7` in the Decode stage and carries the control word through ID/EX, EX/MEM and MEM/WB registers. Stall and flush inputs from the hazard unit act on those registers. It resolves all six RV32I branch conditions plus `jal`/`jalr` in Execute and drives the next-PC select.

---
 rtl/pipe_control_unit.sv | 264 ++++++++++++++++++++++++++
 tb/tb_pipe_control_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control_unit.sv
// Pipelined RV32I control unit: decodes in D, carries the control word through ID/EX, EX/MEM and
// MEM/WB, and resolves branches/jumps in E. Define MULDIV_EN to add RV32M decode.
module pipe_control_unit #(
   parameter int unsigned OP_WIDTH       = 7,
   parameter int unsigned FUNCT3_WIDTH   = 3,
   parameter int unsigned ALU_CTRL_WIDTH = 4,
   parameter int unsigned IMM_SRC_WIDTH  = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [OP_WIDTH-1:0]       op,
   input  logic [FUNCT3_WIDTH-1:0]   funct3,
   input  logic                      funct7_5,
   input  logic                      funct7_0,
   input  logic                      flush_e,
   input  logic                      stall_e,
   input  logic                      flush_m,
   input  logic                      ZeroE,
   input  logic                      LtE,
   input  logic                      LtuE,
   output logic [IMM_SRC_WIDTH-1:0]  ImmSrcD,
   output logic                      IllegalD,
   output logic [ALU_CTRL_WIDTH-1:0] ALUControlE,
   output logic                      ALUSrcAE,
   output logic                      ALUSrcBE,
   output logic [1:0]                PCSrcE,
   output logic                      MemReadE,
   output logic                      RegWriteE,
   output logic                      MemWriteM,
   output logic                      MemReadM,
   output logic                      RegWriteM,
   output logic [1:0]                ResultSrcM,
   output logic                      RegWriteW,
   output logic [1:0]                ResultSrcW
`ifdef MULDIV_EN
   ,
   output logic                      MulDivE,
   output logic [2:0]                MulDivOpE
`endif
);

   localparam logic [6:0] OpRType  = 7'b0110011;
   localparam logic [6:0] OpIAlu   = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;

   localparam logic [3:0] AluAdd   = 4'b0000;
   localparam logic [3:0] AluSub   = 4'b0001;
   localparam logic [3:0] AluAnd   = 4'b0010;
   localparam logic [3:0] AluOr    = 4'b0011;
   localparam logic [3:0] AluXor   = 4'b0100;
   localparam logic [3:0] AluSlt   = 4'b0101;
   localparam logic [3:0] AluSltu  = 4'b0110;
   localparam logic [3:0] AluSll   = 4'b0111;
   localparam logic [3:0] AluSrl   = 4'b1000;
   localparam logic [3:0] AluSra   = 4'b1001;
   localparam logic [3:0] AluPassB = 4'b1010;

   typedef struct packed {
      logic                      reg_write;
      logic                      mem_read;
      logic                      mem_write;
      logic [1:0]                result_src;
      logic                      alu_src_a;
      logic                      alu_src_b;
      logic                      branch;
      logic                      jump;
      logic                      jumpr;
      logic [ALU_CTRL_WIDTH-1:0] alu_ctrl;
      logic [FUNCT3_WIDTH-1:0]   funct3;
`ifdef MULDIV_EN
      logic                      muldiv;
`endif
   } ctrl_e_t;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] result_src;
   } ctrl_m_t;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
   } ctrl_w_t;

   ctrl_e_t    ctrl_d;
   ctrl_e_t    id_ex_d, id_ex_q;
   ctrl_m_t    ex_mem_d, ex_mem_q;
   ctrl_w_t    mem_wb_d, mem_wb_q;
   logic [3:0] alu_fn;
   logic       is_rtype;
   logic       br_taken;

   assign is_rtype = (op == OpRType);

   // Shared R/I ALU decode; only R-type may turn funct3=000 into SUB.
   always_comb begin
      alu_fn = AluAdd;
      case (funct3[2:0])
         3'b000:  alu_fn = (is_rtype && funct7_5) ? AluSub : AluAdd;
         3'b001:  alu_fn = AluSll;
         3'b010:  alu_fn = AluSlt;
         3'b011:  alu_fn = AluSltu;
         3'b100:  alu_fn = AluXor;
         3'b101:  alu_fn = funct7_5 ? AluSra : AluSrl;
         3'b110:  alu_fn = AluOr;
         default: alu_fn = AluAnd;
      endcase
   end

   always_comb begin
      ctrl_d        = '0;
      ctrl_d.funct3 = funct3;
      ImmSrcD       = '0;
      IllegalD      = 1'b0;
      case (op)
         OpRType: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_ctrl  = ALU_CTRL_WIDTH'(alu_fn);
`ifdef MULDIV_EN
            if (funct7_0) begin
               ctrl_d.muldiv   = 1'b1;
               ctrl_d.alu_ctrl = ALU_CTRL_WIDTH'(AluAdd);
            end
`endif
         end
         OpIAlu: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_src_b = 1'b1;
            ctrl_d.alu_ctrl  = ALU_CTRL_WIDTH'(alu_fn);
         end
         OpLoad: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.mem_read   = 1'b1;
            ctrl_d.result_src = 2'b01;
            ctrl_d.alu_src_b  = 1'b1;
            ctrl_d.alu_ctrl   = ALU_CTRL_WIDTH'(AluAdd);
         end
         OpStore: begin
            ctrl_d.mem_write = 1'b1;
            ctrl_d.alu_src_b = 1'b1;
            ctrl_d.alu_ctrl  = ALU_CTRL_WIDTH'(AluAdd);
            ImmSrcD          = IMM_SRC_WIDTH'(3'b001);
         end
         OpBranch: begin
            ctrl_d.branch   = 1'b1;
            ctrl_d.alu_ctrl = ALU_CTRL_WIDTH'(AluSub);
            ImmSrcD         = IMM_SRC_WIDTH'(3'b010);
         end
         OpJal: begin
            ctrl_d.jump       = 1'b1;
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.result_src = 2'b10;
            ImmSrcD           = IMM_SRC_WIDTH'(3'b011);
         end
         OpJalr: begin
            ctrl_d.jumpr      = 1'b1;
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.result_src = 2'b10;
            ctrl_d.alu_src_b  = 1'b1;
            ctrl_d.alu_ctrl   = ALU_CTRL_WIDTH'(AluAdd);
         end
         OpLui: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_src_b = 1'b1;
            ctrl_d.alu_ctrl  = ALU_CTRL_WIDTH'(AluPassB);
            ImmSrcD          = IMM_SRC_WIDTH'(3'b100);
         end
         OpAuipc: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_src_a = 1'b1;
            ctrl_d.alu_src_b = 1'b1;
            ctrl_d.alu_ctrl  = ALU_CTRL_WIDTH'(AluAdd);
            ImmSrcD          = IMM_SRC_WIDTH'(3'b100);
         end
         default: begin
            ctrl_d   = '0;
            IllegalD = 1'b1;
         end
      endcase
   end

`ifndef MULDIV_EN
   logic unused_funct7_0;
   assign unused_funct7_0 = funct7_0;
`endif

   // A stall holds E and drops a bubble into M; flushes win over the stall.
   always_comb begin
      if (flush_e)      id_ex_d = '0;
      else if (stall_e) id_ex_d = id_ex_q;
      else              id_ex_d = ctrl_d;

      if (flush_m || stall_e) begin
         ex_mem_d = '0;
      end else begin
         ex_mem_d.reg_write  = id_ex_q.reg_write;
         ex_mem_d.mem_read   = id_ex_q.mem_read;
         ex_mem_d.mem_write  = id_ex_q.mem_write;
         ex_mem_d.result_src = id_ex_q.result_src;
      end

      mem_wb_d.reg_write  = ex_mem_q.reg_write;
      mem_wb_d.result_src = ex_mem_q.result_src;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         id_ex_q  <= '0;
         ex_mem_q <= '0;
         mem_wb_q <= '0;
      end else begin
         id_ex_q  <= id_ex_d;
         ex_mem_q <= ex_mem_d;
         mem_wb_q <= mem_wb_d;
      end
   end

   always_comb begin
      case (id_ex_q.funct3[2:0])
         3'b000:  br_taken = ZeroE;
         3'b001:  br_taken = !ZeroE;
         3'b100:  br_taken = LtE;
         3'b101:  br_taken = !LtE;
         3'b110:  br_taken = LtuE;
         3'b111:  br_taken = !LtuE;
         default: br_taken = 1'b0;
      endcase
   end

   // Redirect is suppressed while held so a stalled branch redirects only once.
   always_comb begin
      PCSrcE = 2'b00;
      if (!stall_e) begin
         if (id_ex_q.jumpr)                                    PCSrcE = 2'b10;
         else if (id_ex_q.jump || (id_ex_q.branch && br_taken)) PCSrcE = 2'b01;
      end
   end

   assign ALUControlE = id_ex_q.alu_ctrl;
   assign ALUSrcAE    = id_ex_q.alu_src_a;
   assign ALUSrcBE    = id_ex_q.alu_src_b;
   assign MemReadE    = id_ex_q.mem_read;
   assign RegWriteE   = id_ex_q.reg_write;
   assign MemWriteM   = ex_mem_q.mem_write;
   assign MemReadM    = ex_mem_q.mem_read;
   assign RegWriteM   = ex_mem_q.reg_write;
   assign ResultSrcM  = ex_mem_q.result_src;
   assign RegWriteW   = mem_wb_q.reg_write;
   assign ResultSrcW  = mem_wb_q.result_src;

`ifdef MULDIV_EN
   assign MulDivE   = id_ex_q.muldiv;
   assign MulDivOpE = id_ex_q.muldiv ? id_ex_q.funct3[2:0] : 3'b000;
`endif

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed self-checking bench for pipe_control_unit; covers MULDIV_EN when defined.
module tb_pipe_control_unit;

   localparam logic [6:0] OpR  = 7'b0110011;
   localparam logic [6:0] OpI  = 7'b0010011;
   localparam logic [6:0] OpLd = 7'b0000011;
   localparam logic [6:0] OpSt = 7'b0100011;
   localparam logic [6:0] OpBr = 7'b1100011;
   localparam logic [6:0] OpJl = 7'b1101111;
   localparam logic [6:0] OpJr = 7'b1100111;
   localparam logic [6:0] OpLu = 7'b0110111;
   localparam logic [6:0] OpAu = 7'b0010111;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7_5, funct7_0;
   logic       flush_e, stall_e, flush_m;
   logic       ZeroE, LtE, LtuE;
   logic [2:0] ImmSrcD;
   logic       IllegalD;
   logic [3:0] ALUControlE;
   logic       ALUSrcAE, ALUSrcBE;
   logic [1:0] PCSrcE;
   logic       MemReadE, RegWriteE;
   logic       MemWriteM, MemReadM, RegWriteM;
   logic [1:0] ResultSrcM;
   logic       RegWriteW;
   logic [1:0] ResultSrcW;
`ifdef MULDIV_EN
   logic       MulDivE;
   logic [2:0] MulDivOpE;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_control_unit dut (
      .clk        (clk),
      .rst        (rst),
      .op         (op),
      .funct3     (funct3),
      .funct7_5   (funct7_5),
      .funct7_0   (funct7_0),
      .flush_e    (flush_e),
      .stall_e    (stall_e),
      .flush_m    (flush_m),
      .ZeroE      (ZeroE),
      .LtE        (LtE),
      .LtuE       (LtuE),
      .ImmSrcD    (ImmSrcD),
      .IllegalD   (IllegalD),
      .ALUControlE(ALUControlE),
      .ALUSrcAE   (ALUSrcAE),
      .ALUSrcBE   (ALUSrcBE),
      .PCSrcE     (PCSrcE),
      .MemReadE   (MemReadE),
      .RegWriteE  (RegWriteE),
      .MemWriteM  (MemWriteM),
      .MemReadM   (MemReadM),
      .RegWriteM  (RegWriteM),
      .ResultSrcM (ResultSrcM),
      .RegWriteW  (RegWriteW),
      .ResultSrcW (ResultSrcW)
`ifdef MULDIV_EN
      ,
      .MulDivE    (MulDivE),
      .MulDivOpE  (MulDivOpE)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f75,
                        input logic f70);
      op       = o;
      funct3   = f3;
      funct7_5 = f75;
      funct7_0 = f70;
   endtask

   task automatic idle();
      instr(7'b0000000, 3'b000, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; flush_e = 1'b0; stall_e = 1'b0; flush_m = 1'b0;
      ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;
      idle();
      tick(); tick();
      rst = 1'b0;
      check("rst_regwrite_e", RegWriteE, 0);
      check("rst_pcsrc_e", PCSrcE, 0);
      check("rst_memread_m", MemReadM, 0);
      check("rst_regwrite_w", RegWriteW, 0);
      check("rst_resultsrc_w", ResultSrcW, 0);
      check("illegal_zero_op", IllegalD, 1);

      // add, sub, sra, addi with instr[30] set, srai, sltiu
      instr(OpR, 3'b000, 1'b0, 1'b0); tick();
      check("alu_add", ALUControlE, 4'b0000);
      check("add_regwrite_e", RegWriteE, 1);
      instr(OpR, 3'b000, 1'b1, 1'b0); tick();
      check("alu_sub", ALUControlE, 4'b0001);
      instr(OpR, 3'b101, 1'b1, 1'b0); tick();
      check("alu_sra", ALUControlE, 4'b1001);
      check("add_regwrite_w", RegWriteW, 1);
      instr(OpI, 3'b000, 1'b1, 1'b0); tick();
      check("alu_addi_not_sub", ALUControlE, 4'b0000);
      check("addi_alusrcb", ALUSrcBE, 1);
      check("sub_regwrite_w", RegWriteW, 1);
      instr(OpI, 3'b101, 1'b1, 1'b0); tick();
      check("alu_srai", ALUControlE, 4'b1001);
      check("sra_regwrite_w", RegWriteW, 1);
      instr(OpI, 3'b011, 1'b0, 1'b0); tick();
      check("alu_sltiu", ALUControlE, 4'b0110);
      idle(); tick();

      // load
      instr(OpLd, 3'b010, 1'b0, 1'b0); #1;
      check("lw_immsrc", ImmSrcD, 3'b000);
      check("lw_legal", IllegalD, 0);
      tick();
      check("lw_memread_e", MemReadE, 1);
      check("lw_alu_add", ALUControlE, 4'b0000);
      idle(); tick();
      check("lw_memread_m", MemReadM, 1);
      check("lw_resultsrc_m", ResultSrcM, 2'b01);
      check("idle_memread_e", MemReadE, 0);
      tick();
      check("lw_resultsrc_w", ResultSrcW, 2'b01);

      // branches
      instr(OpBr, 3'b001, 1'b0, 1'b0); ZeroE = 1'b0; #1;
      check("br_immsrc", ImmSrcD, 3'b010);
      tick();
      check("bne_taken", PCSrcE, 2'b01);
      check("br_alu_sub", ALUControlE, 4'b0001);
      ZeroE = 1'b1; #1;
      check("bne_not_taken", PCSrcE, 2'b00);
      instr(OpBr, 3'b110, 1'b0, 1'b0); ZeroE = 1'b0; LtuE = 1'b1; tick();
      check("bltu_taken", PCSrcE, 2'b01);
      LtuE = 1'b0; #1;
      check("bltu_not_taken", PCSrcE, 2'b00);
      instr(OpBr, 3'b101, 1'b0, 1'b0); LtE = 1'b1; tick();
      check("bge_not_taken", PCSrcE, 2'b00);
      LtE = 1'b0; #1;
      check("bge_taken", PCSrcE, 2'b01);
      instr(OpBr, 3'b010, 1'b0, 1'b0); ZeroE = 1'b1; LtE = 1'b1; LtuE = 1'b1; tick();
      check("br_f3_010_never", PCSrcE, 2'b00);
      ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;

      // jal, then jalr held by stall for two cycles
      instr(OpJl, 3'b000, 1'b0, 1'b0); #1;
      check("jal_immsrc", ImmSrcD, 3'b011);
      tick();
      check("jal_pcsrc", PCSrcE, 2'b01);
      instr(OpJr, 3'b000, 1'b0, 1'b0); tick();
      check("jalr_pcsrc", PCSrcE, 2'b10);
      check("jal_regwrite_m", RegWriteM, 1);
      check("jal_resultsrc_m", ResultSrcM, 2'b10);
      idle(); stall_e = 1'b1; #1;
      check("jalr_stall_pcsrc0", PCSrcE, 2'b00);
      tick();
      check("jalr_stall_pcsrc1", PCSrcE, 2'b00);
      check("stall_regwrite_m1", RegWriteM, 0);
      check("stall_memwrite_m1", MemWriteM, 0);
      check("stall_holds_e", RegWriteE, 1);
      tick();
      check("jalr_stall_pcsrc2", PCSrcE, 2'b00);
      check("stall_regwrite_m2", RegWriteM, 0);
      stall_e = 1'b0; #1;
      check("jalr_release_pcsrc", PCSrcE, 2'b10);
      tick();
      check("jalr_regwrite_m", RegWriteM, 1);
      check("jalr_resultsrc_m", ResultSrcM, 2'b10);
      check("after_jalr_pcsrc", PCSrcE, 2'b00);

      // store, then store under simultaneous flush_e and stall_e
      instr(OpSt, 3'b010, 1'b0, 1'b0); #1;
      check("sw_immsrc", ImmSrcD, 3'b001);
      tick();
      check("sw_alusrcb", ALUSrcBE, 1);
      check("sw_regwrite_e", RegWriteE, 0);
      idle(); tick();
      check("sw_memwrite_m", MemWriteM, 1);
      instr(OpI, 3'b000, 1'b0, 1'b0); tick();
      instr(OpSt, 3'b010, 1'b0, 1'b0); flush_e = 1'b1; stall_e = 1'b1; tick();
      check("flst_regwrite_e", RegWriteE, 0);
      check("flst_alusrcb_e", ALUSrcBE, 0);
      check("flst_regwrite_m", RegWriteM, 0);
      flush_e = 1'b0; stall_e = 1'b0; idle(); tick();
      check("flst_memwrite_m", MemWriteM, 0);
      check("flst_regwrite_m2", RegWriteM, 0);

      // lui, auipc with flush_m, plain flush_e
      instr(OpLu, 3'b000, 1'b0, 1'b0); #1;
      check("lui_immsrc", ImmSrcD, 3'b100);
      tick();
      check("lui_alu_passb", ALUControlE, 4'b1010);
      check("lui_regwrite_e", RegWriteE, 1);
      instr(OpAu, 3'b000, 1'b0, 1'b0); flush_m = 1'b1; tick();
      check("auipc_alusrca", ALUSrcAE, 1);
      check("auipc_alu_add", ALUControlE, 4'b0000);
      check("flush_m_bubble", RegWriteM, 0);
      flush_m = 1'b0; instr(OpR, 3'b000, 1'b0, 1'b0); flush_e = 1'b1; tick();
      check("flush_e_bubble", RegWriteE, 0);
      check("auipc_regwrite_m", RegWriteM, 1);
      flush_e = 1'b0;

      // illegal opcode
      instr(7'b1111111, 3'b000, 1'b0, 1'b0); #1;
      check("illegal_op", IllegalD, 1);
      check("illegal_immsrc", ImmSrcD, 3'b000);
      tick();
      check("illegal_bubble_e", RegWriteE, 0);

      // reset mid-stream while stalled
      instr(OpR, 3'b000, 1'b0, 1'b0); tick(); tick(); tick();
      check("pre_rst_regwrite_w", RegWriteW, 1);
      rst = 1'b1; stall_e = 1'b1; tick();
      check("rst_mid_regwrite_w", RegWriteW, 0);
      check("rst_mid_resultsrc_w", ResultSrcW, 0);
      check("rst_mid_regwrite_m", RegWriteM, 0);
      check("rst_mid_regwrite_e", RegWriteE, 0);
      rst = 1'b0; idle(); tick();
      check("rst_held_word_lost", RegWriteE, 0);
      stall_e = 1'b0;

      // RV32M encodings
      instr(OpR, 3'b000, 1'b0, 1'b1); tick();
      check("mul_alu", ALUControlE, 4'b0000);
      check("mul_regwrite_e", RegWriteE, 1);
`ifdef MULDIV_EN
      check("mul_muldiv_e", MulDivE, 1);
      check("mul_muldivop_e", MulDivOpE, 3'b000);
`endif
      instr(OpR, 3'b011, 1'b0, 1'b1); tick();
`ifdef MULDIV_EN
      check("mulhu_alu", ALUControlE, 4'b0000);
      check("mulhu_muldiv_e", MulDivE, 1);
      check("mulhu_muldivop_e", MulDivOpE, 3'b011);
`else
      check("mulhu_as_sltu", ALUControlE, 4'b0110);
`endif
      idle(); tick();
      check("end_regwrite_e", RegWriteE, 0);
`ifdef MULDIV_EN
      check("end_muldiv_e", MulDivE, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
